tcon_unloader: RTL and testbench
================================

Name: tcon_unloader

Overview:
- Reader side of the tcon load/hold word transfer.
- The upstream controller presents a WIDTH-bit word with a load strobe. This block captures the word into a holding register using the same rule: load asserted → take new data, else keep current.
- It then drains the held word serially over a valid/ready stream toward the power-analysis scan path.
- It provides back-pressure, so a new word is accepted only after the previous word has fully drained.

Parameters:
- WIDTH, 8, bits per transferred word (8 channels a..h / k..r); legal range 2..32.
- LSB_FIRST, 0, 0 = shift out MSB first, 1 = LSB first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_i  input  1  load strobe from the word source (the "i" select).
- load_data  input  WIDTH  word presented with load_i.
- load_ready  output  1  high when a load will be accepted this cycle.
- hold_data  output  WIDTH  current holding-register contents (the registered a0..h0 view).
- ser_valid  output  1  a serial bit is presented.
- ser_ready  input  1  downstream accepts the bit.
- ser_data  output  1  current serial bit.
- ser_last  output  1  marks the final bit of a word.
- busy  output  1  high while a word is draining.

Behaviour:
- Reset (async on rst_n low): hold_data=0, shift register=0, bit counter=0, state=IDLE. Outputs: ser_valid=0, ser_data=0, ser_last=0, busy=0, load_ready=1.
- Load acceptance:
  - Accept when load_i & load_ready at a rising edge.
  - On accept: hold_data<=load_data, shift<=load_data, cnt<=WIDTH-1, state<=SHIFT.
  - load_i while load_ready=0 is ignored; hold_data is unchanged (hold semantics).
- FSM states:
  - IDLE: load_ready=1, ser_valid=0. Accept → SHIFT.
  - SHIFT: ser_valid=1, busy=1, load_ready=0.
    - ser_data = shift[WIDTH-1] (MSB first) or shift[0] (LSB first).
    - ser_last = (cnt==0) when parity is off.
  - On ser_valid & ser_ready in SHIFT:
    - Shift one position toward the output end, filling with 0.
    - If cnt==0 → IDLE (or PAR when the parity feature is built in); otherwise cnt<=cnt-1.
  - ser_ready low: ser_data, ser_last and cnt are held stable. No bit may change while valid and not ready.
- Latency: first bit is valid the cycle after accept. Minimum word period is WIDTH cycles with ser_ready tied high, plus 1 cycle in IDLE for the next accept. No same-cycle reload on the last beat.
- hold_data persists after drain until the next accept; it does not shift.
- cnt width = $clog2(WIDTH). Counter never wraps; underflow is impossible by construction.
- Reset mid-word: the word is discarded, outputs return to reset values immediately (async), and no partial ser_last is issued.

Optional Feature:
- Macro TCON_UNLOADER_PARITY_EN.
- Defined:
  - Extra state PAR after the last data bit.
  - ser_data = even parity (XOR) of the accepted word; ser_valid=1, ser_last=1 only in PAR.
  - Handshake in PAR → IDLE.
  - Word period is WIDTH+1 beats.
- Undefined: no PAR state; ser_last asserts on the final data bit; the XOR logic is absent.

Decomposition:
- Package tcon_pkg holds:
  - state enum typedef (IDLE, SHIFT, PAR).
  - localparam default TCON_WIDTH=8.
  - function for even parity.
- No sub-module required. Optional tcon_hold_reg (WIDTH-bit load/hold flop with async reset) may be factored out, since the writer side uses the same structure.

Test Plan:
- Reset then idle: rst_n low mid-operation → all outputs at reset values within the same cycle. After release, load_ready=1, ser_valid=0.
- Basic MSB-first load: load_data=8'hA5, load_i=1 for 1 cycle, ser_ready=1 → bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, ser_last on the 8th; hold_data=8'hA5 thereafter.
- LSB_FIRST=1, load 8'h01 → first bit 1, then seven 0s; ser_last on the 8th beat.
- Back-pressure: load 8'hC3, toggle ser_ready 1,0,0,1,... → data/last stable while stalled; exactly 8 handshakes; sequence 1,1,0,0,0,0,1,1.
- Load while busy: second load_i=1 with 8'hFF during the drain of 8'h0F → ignored; hold_data stays 8'h0F; the stream is unaffected.
- With TCON_UNLOADER_PARITY_EN: load 8'h07 → 8 data beats (ser_last=0), then a 9th beat with ser_data=1 and ser_last=1; load 8'h03 → 9th beat with ser_data=0.

Source files
------------

// File: rtl/tcon_unloader_pkg.sv
// Shared definitions for the tcon load/hold word unloader: FSM state
// encoding, default word width and the even-parity helper used by the
// optional trailing parity beat.
package tcon_pkg;

    localparam int TCON_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } tcon_state_e;

    // Even parity of a zero-extended word: 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/tcon_unloader_if.sv
// Word-load and serial-stream bundle between the upstream word source,
// the unloader and the scan-path consumer.
interface tcon_unloader_if
    import tcon_pkg::*;
#(
    parameter int WIDTH = TCON_WIDTH
);
    logic             load_i;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic [WIDTH-1:0] hold_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_i, load_data, ser_ready,
        input  load_ready, hold_data, ser_valid, ser_data, ser_last, busy
    );

    modport slave (
        input  load_i, load_data, ser_ready,
        output load_ready, hold_data, ser_valid, ser_data, ser_last, busy
    );
endinterface

// File: rtl/tcon_unloader_hold_reg.sv
// WIDTH-bit load/hold flop: takes new data when load is high, otherwise
// keeps its contents. Same structure as the writer-side holding register.
module tcon_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;

    // Holding register: capture on load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            q_q <= d_i;
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/tcon_unloader.sv
// tcon_unloader: captures a word from the upstream controller into a
// holding register and drains it serially over a valid/ready stream.
// A new word is accepted only in IDLE, i.e. after the previous word
// has fully drained.
// Optional build macro TCON_UNLOADER_PARITY_EN appends an even-parity
// beat (PAR state) after the last data bit; ser_last then marks it.
module tcon_unloader
    import tcon_pkg::*;
#(
    parameter int WIDTH     = TCON_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    tcon_unloader_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);

    tcon_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] hold_s;
    logic [WIDTH-1:0] shifted_s;
    logic             out_bit_s;
    logic             accept_s;
    logic             beat_s;
    logic             ser_valid_s;
    logic             ser_data_s;
    logic             ser_last_s;
    logic             busy_s;
    logic             load_ready_s;

    assign accept_s  = bus.load_i & load_ready_s;
    assign beat_s    = ser_valid_s & bus.ser_ready;
    assign out_bit_s = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
    assign shifted_s = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                                 : {shift_q[WIDTH-2:0], 1'b0};

    tcon_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept_s),
        .d_i    (bus.load_data),
        .q_o    (hold_s)
    );

    // State, shift register and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, shift one bit per handshake.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                    shift_d = bus.load_data;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (beat_s) begin
                    shift_d = shifted_s;
                    if (cnt_q == {CW{1'b0}}) begin
`ifdef TCON_UNLOADER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef TCON_UNLOADER_PARITY_EN
            PAR: begin
                if (beat_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = PAR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        ser_valid_s  = 1'b0;
        ser_data_s   = 1'b0;
        ser_last_s   = 1'b0;
        busy_s       = 1'b0;
        load_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready_s = 1'b1;
            end
            SHIFT: begin
                ser_valid_s = 1'b1;
                busy_s      = 1'b1;
                ser_data_s  = out_bit_s;
`ifdef TCON_UNLOADER_PARITY_EN
                ser_last_s  = 1'b0;
`else
                ser_last_s  = (cnt_q == {CW{1'b0}});
`endif
            end
`ifdef TCON_UNLOADER_PARITY_EN
            PAR: begin
                ser_valid_s = 1'b1;
                busy_s      = 1'b1;
                ser_data_s  = even_parity(32'(hold_s));
                ser_last_s  = 1'b1;
            end
`endif
            default: begin
                load_ready_s = 1'b0;
            end
        endcase
    end

    assign bus.load_ready = load_ready_s;
    assign bus.hold_data  = hold_s;
    assign bus.ser_valid  = ser_valid_s;
    assign bus.ser_data   = ser_data_s;
    assign bus.ser_last   = ser_last_s;
    assign bus.busy       = busy_s;
endmodule

// File: tb/tb_tcon_unloader.sv
// Directed, table-driven bench for tcon_unloader (MSB-first and
// LSB-first instances), with hand-written multi-cycle sequences for
// back-pressure, load-while-busy and asynchronous reset.
module tb_tcon_unloader;

`ifdef TCON_UNLOADER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tcon_unloader_if #(.WIDTH(8)) if_m ();
    tcon_unloader_if #(.WIDTH(8)) if_l ();

    tcon_unloader #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    tcon_unloader #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       rdy;
        logic       e_v;
        logic       e_d;
        logic       e_l;
        logic       e_lr;
        logic [7:0] e_h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic rdy,
                                input logic e_v, input logic e_d, input logic e_l,
                                input logic e_lr, input logic [7:0] e_h);
        vec_t v;
        v.ld = ld; v.d = d; v.rdy = rdy;
        v.e_v = e_v; v.e_d = e_d; v.e_l = e_l; v.e_lr = e_lr; v.e_h = e_h;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_m_valid"}, if_m.ser_valid, 1'b0);
        chk({nm, "_m_data"},  if_m.ser_data, 1'b0);
        chk({nm, "_m_last"},  if_m.ser_last, 1'b0);
        chk({nm, "_m_busy"},  if_m.busy, 1'b0);
        chk({nm, "_m_lr"},    if_m.load_ready, 1'b1);
        chk({nm, "_m_hold"},  if_m.hold_data, 8'h00);
        chk({nm, "_l_valid"}, if_l.ser_valid, 1'b0);
        chk({nm, "_l_lr"},    if_l.load_ready, 1'b1);
    endtask

    // Load word w into the MSB-first instance and drain it, optionally with
    // ser_ready stalls (pattern 1,0,0,1) and optionally poking load_i=1 with
    // 8'hFF during the drain. exp_bits[k] is the k-th serial bit expected.
    task automatic stream_word(input string nm, input logic [7:0] w,
                               input logic [8:0] exp_bits, input bit bp, input bit poke);
        int         hs;
        int         cyc;
        int         exp_n;
        logic       pv, pr, pd, pl, r;
        logic [3:0] pat;
        logic [8:0] got_b;
        logic [8:0] got_l;
        hs = 0; cyc = 0; exp_n = 8 + P;
        pat = 4'b1001;
        pv = 1'b0; pr = 1'b1; pd = 1'b0; pl = 1'b0;
        got_b = 9'h000; got_l = 9'h000;
        if_m.load_i = 1'b1; if_m.load_data = w; if_m.ser_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if_m.load_i = 1'b0; if_m.load_data = 8'h00;
        chk({nm, "_first_valid"}, if_m.ser_valid, 1'b1);
        chk({nm, "_busy"}, if_m.busy, 1'b1);
        while (hs < exp_n && cyc < 100) begin
            if (pv && !pr) begin
                chk({nm, "_stall_data"}, if_m.ser_data, pd);
                chk({nm, "_stall_last"}, if_m.ser_last, pl);
            end
            r = bp ? pat[cyc % 4] : 1'b1;
            if_m.ser_ready = r;
            if (poke && cyc >= 1 && cyc <= 3) begin
                if_m.load_i = 1'b1; if_m.load_data = 8'hFF;
            end else begin
                if_m.load_i = 1'b0; if_m.load_data = 8'h00;
            end
            if (if_m.ser_valid && r) begin
                got_b[hs] = if_m.ser_data;
                got_l[hs] = if_m.ser_last;
                hs++;
            end
            pv = if_m.ser_valid; pr = r; pd = if_m.ser_data; pl = if_m.ser_last;
            cyc++;
            @(posedge clk); @(negedge clk);
            if (poke) chk({nm, "_hold_during"}, if_m.hold_data, w);
        end
        if_m.load_i = 1'b0; if_m.ser_ready = 1'b1;
        chk({nm, "_handshakes"}, hs, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            chk($sformatf("%s_bit%0d", nm, k), got_b[k], exp_bits[k]);
            chk($sformatf("%s_last%0d", nm, k), got_l[k], (k == exp_n - 1));
        end
        chk({nm, "_done_valid"}, if_m.ser_valid, 1'b0);
        chk({nm, "_done_lr"}, if_m.load_ready, 1'b1);
        chk({nm, "_hold"}, if_m.hold_data, w);
    endtask

    initial begin
        logic [8:0] lsb_exp;

        // A5 MSB first, ready high: bits 1,0,1,0,0,1,0,1.
        vecs.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5));
`ifdef TCON_UNLOADER_PARITY_EN
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5));
`else
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5));
`endif
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5));

        if_m.load_i = 1'b0; if_m.load_data = 8'h00; if_m.ser_ready = 1'b1;
        if_l.load_i = 1'b0; if_l.load_data = 8'h00; if_l.ser_ready = 1'b1;

        // Reset state while held in reset, then after release.
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_outputs("after_release");

        // Table-driven MSB-first drain of A5.
        foreach (vecs[i]) begin
            if_m.load_i = vecs[i].ld; if_m.load_data = vecs[i].d; if_m.ser_ready = vecs[i].rdy;
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_valid", i), if_m.ser_valid, vecs[i].e_v);
            chk($sformatf("vec%0d_data", i),  if_m.ser_data, vecs[i].e_d);
            chk($sformatf("vec%0d_last", i),  if_m.ser_last, vecs[i].e_l);
            chk($sformatf("vec%0d_lr", i),    if_m.load_ready, vecs[i].e_lr);
            chk($sformatf("vec%0d_hold", i),  if_m.hold_data, vecs[i].e_h);
        end
        if_m.load_i = 1'b0;

        // Back-pressure on C3: 1,1,0,0,0,0,1,1 then parity 0.
        stream_word("bp_c3", 8'hC3, 9'b0_1100_0011, 1'b1, 1'b0);
        // Load while busy: FF ignored during drain of 0F.
        stream_word("busy_0f", 8'h0F, 9'b0_1111_0000, 1'b0, 1'b1);
`ifdef TCON_UNLOADER_PARITY_EN
        stream_word("par_07", 8'h07, 9'b1_1110_0000, 1'b0, 1'b0);
        stream_word("par_03", 8'h03, 9'b0_1100_0000, 1'b0, 1'b0);
`endif

        // LSB-first instance, word 01: 1 then seven 0s (parity 1).
        lsb_exp = 9'b1_0000_0001;
        if_l.load_i = 1'b1; if_l.load_data = 8'h01; if_l.ser_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if_l.load_i = 1'b0; if_l.load_data = 8'h00;
        for (int k = 0; k < 8 + P; k++) begin
            chk($sformatf("lsb_valid%0d", k), if_l.ser_valid, 1'b1);
            chk($sformatf("lsb_data%0d", k), if_l.ser_data, lsb_exp[k]);
            chk($sformatf("lsb_last%0d", k), if_l.ser_last, (k == 7 + P));
            @(posedge clk); @(negedge clk);
        end
        chk("lsb_idle_valid", if_l.ser_valid, 1'b0);
        chk("lsb_hold", if_l.hold_data, 8'h01);

        // Asynchronous reset in the middle of a word.
        if_m.load_i = 1'b1; if_m.load_data = 8'hC3; if_m.ser_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if_m.load_i = 1'b0; if_m.load_data = 8'h00;
        @(posedge clk); @(negedge clk);
        chk("mid_valid", if_m.ser_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_reset_lr", if_m.load_ready, 1'b1);
        chk("post_reset_valid", if_m.ser_valid, 1'b0);
        chk("post_reset_last", if_m.ser_last, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
